// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FPU divider: FSM states, rounding modes,
// exponent bias, special-value patterns and the quotient iteration count.
package fpu_div_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_CHECK = 4'd2,
        ST_EXP   = 4'd3,
        ST_DIV   = 4'd4,
        ST_NORM  = 4'd5,
        ST_ROUND = 4'd6,
        ST_FINAL = 4'd7,
        ST_READY = 4'd8
    } state_e;

    localparam logic [1:0] RM_TRUNC     = 2'b00;
    localparam logic [1:0] RM_NEG_INF   = 2'b01;
    localparam logic [1:0] RM_POS_INF   = 2'b10;
    localparam logic [1:0] RM_TRUNC_ALT = 2'b11;

    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] INF_SP  = 32'h7F80_0000;
    localparam logic [63:0] QNAN_DP = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF_DP  = 64'h7FF0_0000_0000_0000;

    // 127 for single, 1023 for double
    function automatic int unsigned exp_bias(input int unsigned ew);
        return (32'd1 << (ew - 32'd1)) - 32'd1;
    endfunction

    // Quotient bits produced for a stored significand width of sw
    function automatic int unsigned div_iters(input int unsigned sw);
        return sw + 32'd2;
    endfunction

endpackage

// File: rtl/fpu_division_function_sgf_divider.sv
// Radix-2 restoring significand divider: Q = floor(mx * 2^N / my), one bit per clock,
// with a sticky bit for a nonzero final remainder.
module sgf_restoring_divider
    import fpu_div_pkg::*;
#(
    parameter int unsigned N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] mx,
    input  logic [N-1:0] my,
    output logic [N:0]   q,
    output logic         sticky,
    output logic         done
);

    localparam int unsigned QW = div_iters(N - 32'd1);
    localparam int unsigned RW = N + 32'd2;
    localparam int unsigned CW = $clog2(QW + 32'd1);

    logic [RW-1:0] rem_q, rem_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [QW-1:0] quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sticky_q, sticky_d;
    logic          ge_c;
    logic [RW-1:0] trial_c;
    logic [RW-1:0] rsel_c;

    // Partial remainder stays below 2*divisor, so one compare decides each bit
    always_comb begin
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sticky_d = sticky_q;
        ge_c     = (rem_q >= RW'(dvs_q));
        trial_c  = rem_q - RW'(dvs_q);
        rsel_c   = ge_c ? trial_c : rem_q;
        if (start) begin
            rem_d    = RW'(mx);
            dvs_d    = my;
            quo_d    = '0;
            cnt_d    = CW'(QW);
            busy_d   = 1'b1;
            sticky_d = 1'b0;
        end else if (busy_q) begin
            quo_d = {quo_q[QW-2:0], ge_c};
            rem_d = rsel_c << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                sticky_d = (rsel_c != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sticky_q <= sticky_d;
        end
    end

    assign q      = quo_q;
    assign sticky = sticky_q;
    assign done   = done_q;

endmodule

// File: rtl/fpu_division_function.sv
// Multi-cycle IEEE-754 divider (Data_MX / Data_MY) with the FPU beg/ready/ack
// handshake, directed rounding and overflow/underflow/divide-by-zero flags.
module fpu_division_function
    import fpu_div_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned EW = 8,
    parameter int unsigned SW = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         beg_FSM,
    input  logic         ack_FSM,
    input  logic [W-1:0] Data_MX,
    input  logic [W-1:0] Data_MY,
    input  logic [1:0]   round_mode,
    output logic         overflow_flag,
    output logic         underflow_flag,
    output logic         div_zero_flag,
    output logic         ready,
    output logic [W-1:0] final_result_ieee
);

    localparam int unsigned EXW = EW + 32'd2;
    localparam int unsigned MW  = SW + 32'd1;

    localparam logic signed [EXW-1:0] EXP_BIAS = EXW'(exp_bias(EW));
    localparam logic signed [EXW-1:0] EXP_ONE  = EXW'(1);
    localparam logic signed [EXW-1:0] EXP_ZERO = '0;
    localparam logic signed [EXW-1:0] EXP_MAX  = EXW'((32'd1 << EW) - 32'd1);

    localparam logic [W-1:0] QNAN    = (W == 32'd64) ? W'(QNAN_DP) : W'(QNAN_SP);
    localparam logic [W-2:0] INF_MAG = (W == 32'd64) ? (W-1)'(INF_DP) : (W-1)'(INF_SP);

    state_e                 state_q, state_d;
    logic [W-1:0]           x_q, x_d, y_q, y_d;
    logic [1:0]             mode_q, mode_d;
    logic                   sign_q, sign_d;
    logic signed [EXW-1:0]  exp_q, exp_d;
    logic [MW-1:0]          mant_q, mant_d;
    logic                   inexact_q, inexact_d;
    logic                   special_q, special_d;
    logic [W-1:0]           spec_res_q, spec_res_d;
    logic                   spec_dz_q, spec_dz_d;
    logic [W-1:0]           res_q, res_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   dz_q, dz_d;
    logic                   ready_q, ready_d;

    logic                   div_start_c;
    logic [MW:0]            div_quo;
    logic                   div_sticky;
    logic                   div_done;
    logic                   x_zero_c, y_zero_c;
    logic                   round_inc_c;
    logic [MW:0]            mant_inc_c;

    sgf_restoring_divider #(.N(MW)) u_sgf_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start_c),
        .mx     ({1'b1, x_q[SW-1:0]}),
        .my     ({1'b1, y_q[SW-1:0]}),
        .q      (div_quo),
        .sticky (div_sticky),
        .done   (div_done)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        inexact_d   = inexact_q;
        special_d   = special_q;
        spec_res_d  = spec_res_q;
        spec_dz_d   = spec_dz_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        dz_d        = dz_q;
        ready_d     = ready_q;
        // Divider is kicked off in CHECK so its last bit lands as DIV ends
        div_start_c = (state_q == ST_CHECK);
        x_zero_c    = (x_q[W-2:0] == '0);
        y_zero_c    = (y_q[W-2:0] == '0);
        round_inc_c = 1'b0;
        case (mode_q)
            RM_NEG_INF:             round_inc_c = inexact_q & sign_q;
            RM_POS_INF:             round_inc_c = inexact_q & ~sign_q;
            RM_TRUNC, RM_TRUNC_ALT: round_inc_c = 1'b0;
        endcase
        mant_inc_c  = {1'b0, mant_q} + (MW+1)'(round_inc_c);

        case (state_q)
            ST_IDLE: begin
                if (beg_FSM) begin
                    x_d     = Data_MX;
                    y_d     = Data_MY;
                    mode_d  = round_mode;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sign_d  = x_q[W-1] ^ y_q[W-1];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                special_d = 1'b1;
                spec_dz_d = 1'b0;
                state_d   = ST_FINAL;
                if (x_zero_c && y_zero_c) begin
                    spec_res_d = QNAN;
                    spec_dz_d  = 1'b1;
                end else if (y_zero_c) begin
                    spec_res_d = {sign_q, INF_MAG};
                    spec_dz_d  = 1'b1;
                end else if (x_zero_c) begin
                    spec_res_d = {sign_q, {(W-1){1'b0}}};
                end else begin
                    special_d = 1'b0;
                    state_d   = ST_EXP;
                end
            end
            ST_EXP: begin
                exp_d   = $signed(EXW'(x_q[W-2:SW])) - $signed(EXW'(y_q[W-2:SW])) + EXP_BIAS;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (div_quo[MW]) begin
                    mant_d    = div_quo[MW:1];
                    inexact_d = div_quo[0] | div_sticky;
                end else begin
                    mant_d    = div_quo[MW-1:0];
                    inexact_d = div_sticky;
                    exp_d     = exp_q - EXP_ONE;
                end
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                // All-ones significand rounding up wraps to 1.0 at the next exponent
                if (mant_inc_c[MW]) begin
                    mant_d = {1'b1, {SW{1'b0}}};
                    exp_d  = exp_q + EXP_ONE;
                end else begin
                    mant_d = mant_inc_c[MW-1:0];
                end
                state_d = ST_FINAL;
            end
            ST_FINAL: begin
                ready_d = 1'b1;
                state_d = ST_READY;
                if (special_q) begin
                    res_d = spec_res_q;
                    dz_d  = spec_dz_q;
                end else if (exp_q >= EXP_MAX) begin
                    res_d = {sign_q, INF_MAG};
                    ovf_d = 1'b1;
                end else if (exp_q <= EXP_ZERO) begin
                    res_d = {sign_q, {(W-1){1'b0}}};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign_q, exp_q[EW-1:0], mant_q[SW-1:0]};
                end
            end
            ST_READY: begin
                if (ack_FSM) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            inexact_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_dz_q  <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            dz_q       <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mode_q     <= mode_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            inexact_q  <= inexact_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_dz_q  <= spec_dz_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            dz_q       <= dz_d;
            ready_q    <= ready_d;
        end
    end

    assign final_result_ieee = res_q;
    assign overflow_flag     = ovf_q;
    assign underflow_flag    = unf_q;
    assign div_zero_flag     = dz_q;
    assign ready             = ready_q;

endmodule

// File: tb/tb_fpu_division_function.sv
// Bench for the single-precision FPU divider: directed vectors, randomized
// operations against an arithmetic reference model, handshake and reset scenarios.
module tb_fpu_division_function;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        beg_fsm = 1'b0;
    logic        ack_fsm = 1'b0;
    logic [31:0] data_mx = '0;
    logic [31:0] data_my = '0;
    logic [1:0]  round_mode = '0;
    logic        overflow_flag, underflow_flag, div_zero_flag, ready;
    logic [31:0] final_result_ieee;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_division_function #(.W(32), .EW(8), .SW(23)) dut (
        .clk               (clk),
        .rst               (rst),
        .beg_FSM           (beg_fsm),
        .ack_FSM           (ack_fsm),
        .Data_MX           (data_mx),
        .Data_MY           (data_my),
        .round_mode        (round_mode),
        .overflow_flag     (overflow_flag),
        .underflow_flag    (underflow_flag),
        .div_zero_flag     (div_zero_flag),
        .ready             (ready),
        .final_result_ieee (final_result_ieee)
    );

    // Reference: exact integer quotient of the significands, then normalize/round/range-check
    function automatic void model_div(input logic [31:0] x, input logic [31:0] y,
                                      input logic [1:0] m, output logic [31:0] r,
                                      output logic [2:0] f, output int lat);
        logic s, inex, inc;
        longint unsigned mx, my, num, q, rem, mant;
        int e;
        s = x[31] ^ y[31];
        f = 3'b000;
        lat = 3;
        if (x[30:0] == 31'h0 && y[30:0] == 31'h0) begin
            r = 32'h7FC00000; f = 3'b001;
        end else if (y[30:0] == 31'h0) begin
            r = {s, 31'h7F800000}; f = 3'b001;
        end else if (x[30:0] == 31'h0) begin
            r = {s, 31'h0};
        end else begin
            lat = 31;
            mx  = 64'(x[22:0]) + 64'h800000;
            my  = 64'(y[22:0]) + 64'h800000;
            num = mx * 64'h1000000;
            q   = num / my;
            rem = num % my;
            e   = int'(x[30:23]) - int'(y[30:23]) + 127;
            if (q >= 64'h1000000) begin
                mant = q / 2;
                inex = ((q % 2) != 0) || (rem != 0);
            end else begin
                mant = q;
                inex = (rem != 0);
                e = e - 1;
            end
            inc = inex && ((m == 2'b10 && !s) || (m == 2'b01 && s));
            if (inc) mant = mant + 1;
            if (mant == 64'h1000000) begin
                mant = 64'h800000;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0}; f = 3'b100;
            end else if (e <= 0) begin
                r = {s, 31'h0}; f = 3'b010;
            end else begin
                r = {s, 8'(e), 23'(mant)};
            end
        end
    endfunction

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m);
        @(negedge clk);
        data_mx = x;
        data_my = y;
        round_mode = m;
        beg_fsm = 1'b1;
        @(posedge clk);
        #1 beg_fsm = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic ack_op();
        @(negedge clk);
        ack_fsm = 1'b1;
        @(posedge clk);
        #1 ack_fsm = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] m,
                          output logic [31:0] r, output logic [2:0] f, output int cyc);
        start_op(x, y, m);
        wait_ready(cyc);
        r = final_result_ieee;
        f = {overflow_flag, underflow_flag, div_zero_flag};
        ack_op();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        beg_fsm = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 3;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL reset ready: got %b expected 0", ready);
        end
        if (final_result_ieee !== 32'h0) begin
            errors++; $display("FAIL reset result: got %h expected 00000000", final_result_ieee);
        end
        if ({overflow_flag, underflow_flag, div_zero_flag} !== 3'b000) begin
            errors++; $display("FAIL reset flags: got %b expected 000",
                               {overflow_flag, underflow_flag, div_zero_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        beg_fsm = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] tx [11] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                                 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h00000000,
                                 32'h00000000, 32'h80000000, 32'hC0000000};
        logic [31:0] ty [11] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h40400000,
                                 32'h00800000, 32'h7F000000, 32'h00000000, 32'h40A00000,
                                 32'h00000000, 32'h40A00000, 32'h00000000};
        logic [1:0]  tm [11] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00,
                                 2'b00, 2'b00, 2'b00, 2'b11, 2'b10};
        logic [31:0] tr [11] = '{32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB,
                                 32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000,
                                 32'h7FC00000, 32'h80000000, 32'hFF800000};
        logic [2:0]  tf [11] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010,
                                 3'b001, 3'b000, 3'b001, 3'b000, 3'b001};
        int          tl [11] = '{31, 31, 31, 31, 31, 31, 3, 3, 3, 3, 3};
        logic [31:0] r;
        logic [2:0]  f;
        int          cyc;
        for (int i = 0; i < 11; i++) begin
            run_op(tx[i], ty[i], tm[i], r, f, cyc);
            checks += 3;
            if (r !== tr[i]) begin
                errors++; $display("FAIL directed[%0d] result: got %h expected %h", i, r, tr[i]);
            end
            if (f !== tf[i]) begin
                errors++; $display("FAIL directed[%0d] flags(ovf,unf,dz): got %b expected %b", i, f, tf[i]);
            end
            if (cyc !== tl[i]) begin
                errors++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, cyc, tl[i]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] x, y, r, er;
        logic [2:0]  f, ef;
        logic [1:0]  m;
        int          cyc, el;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 3) != 0) y[30:23] = 8'($urandom_range(100, 154));
            if ($urandom_range(0, 9) == 0) x[30:0] = 31'h0;
            if ($urandom_range(0, 9) == 0) y[30:0] = 31'h0;
            m = 2'($urandom_range(0, 3));
            model_div(x, y, m, er, ef, el);
            run_op(x, y, m, r, f, cyc);
            checks += 3;
            if (r !== er) begin
                errors++; $display("FAIL random[%0d] %h/%h m%0d result: got %h expected %h", i, x, y, m, r, er);
            end
            if (f !== ef) begin
                errors++; $display("FAIL random[%0d] %h/%h flags: got %b expected %b", i, x, y, f, ef);
            end
            if (cyc !== el) begin
                errors++; $display("FAIL random[%0d] latency: got %0d expected %0d", i, cyc, el);
            end
        end
    endtask

    task automatic test_hold_until_ack();
        int cyc;
        start_op(32'h3F800000, 32'h40400000, 2'b10);
        wait_ready(cyc);
        checks++;
        if (cyc !== 31) begin
            errors++; $display("FAIL hold latency: got %0d expected 31", cyc);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ready !== 1'b1 || final_result_ieee !== 32'h3EAAAAAB) begin
                errors++; $display("FAIL hold[%0d] ready/result: got %b/%h expected 1/3eaaaaab",
                                   i, ready, final_result_ieee);
            end
        end
        ack_op();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready !== 1'b0 || final_result_ieee !== 32'h3EAAAAAB) begin
                errors++; $display("FAIL after_ack[%0d] ready/result: got %b/%h expected 0/3eaaaaab",
                                   i, ready, final_result_ieee);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_beg_mid_div();
        int cyc;
        start_op(32'h40C00000, 32'h40000000, 2'b00);
        cyc = 0;
        while (ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            beg_fsm = (cyc >= 10 && cyc <= 12);
            ack_fsm = (cyc == 14);
            data_mx = 32'h3F800000;
            data_my = 32'h00000000;
            @(posedge clk);
            #1 cyc++;
        end
        beg_fsm = 1'b0;
        ack_fsm = 1'b0;
        checks += 3;
        if (cyc !== 31) begin
            errors++; $display("FAIL beg_mid_div latency: got %0d expected 31", cyc);
        end
        if (final_result_ieee !== 32'h40400000) begin
            errors++; $display("FAIL beg_mid_div result: got %h expected 40400000", final_result_ieee);
        end
        if (div_zero_flag !== 1'b0) begin
            errors++; $display("FAIL beg_mid_div dz flag: got %b expected 0", div_zero_flag);
        end
        ack_op();
    endtask

    task automatic test_reset_mid_op();
        int cyc, seen;
        logic [31:0] r, er;
        logic [2:0]  f, ef;
        int          el;
        // Reset while holding a result in READY
        start_op(32'h7F000000, 32'h00800000, 2'b00);
        wait_ready(cyc);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, overflow_flag, underflow_flag, div_zero_flag} !== 4'b0000 ||
            final_result_ieee !== 32'h0) begin
            errors++; $display("FAIL reset_in_ready: got rdy/flags %b result %h expected 0000/00000000",
                               {ready, overflow_flag, underflow_flag, div_zero_flag}, final_result_ieee);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset in the twelfth DIV cycle
        start_op(32'h3F800000, 32'h00000003 | 32'h40400000, 2'b10);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ready, overflow_flag, underflow_flag, div_zero_flag} !== 4'b0000 ||
            final_result_ieee !== 32'h0) begin
            errors++; $display("FAIL reset_mid_div: got rdy/flags %b result %h expected 0000/00000000",
                               {ready, overflow_flag, underflow_flag, div_zero_flag}, final_result_ieee);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL reset_idle ready cycles: got %0d expected 0", seen);
        end
        model_div(32'hC1200000, 32'h40400000, 2'b01, er, ef, el);
        run_op(32'hC1200000, 32'h40400000, 2'b01, r, f, cyc);
        checks += 3;
        if (r !== er) begin
            errors++; $display("FAIL post_reset result: got %h expected %h", r, er);
        end
        if (f !== ef) begin
            errors++; $display("FAIL post_reset flags: got %b expected %b", f, ef);
        end
        if (cyc !== el) begin
            errors++; $display("FAIL post_reset latency: got %0d expected %0d", cyc, el);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_until_ack();
        test_beg_mid_div();
        test_reset_mid_op();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
